// File: rtl/palindrome_pkg.sv
// Shared types and constants for the palindrome checker front end.
package palindrome_pkg;
    typedef enum logic [1:0] {IDLE, CONVERT, SCAN, STREAM} state_t;
    localparam int DIGIT_W   = 4;
    localparam int MAX_DIGIT = 15;
    localparam int CNT_W     = $clog2(MAX_DIGIT + 1);
endpackage

// File: rtl/bcd_digit_streamer_if.sv
// Request/stream bundle between a binary source, the streamer and the digit consumer.
interface bcd_digit_streamer_if #(parameter int WIDTH = 32);
    import palindrome_pkg::*;

    logic                 start;
    logic [WIDTH-1:0]     bin_in;
    logic                 digit_ready;
    logic [DIGIT_W-1:0]   digit_out;
    logic                 digit_valid;
    logic [CNT_W-1:0]     digit_count;
    logic                 busy;
    logic                 done;

    modport master (output start, bin_in, digit_ready,
                    input  digit_out, digit_valid, digit_count, busy, done);
    modport slave  (input  start, bin_in, digit_ready,
                    output digit_out, digit_valid, digit_count, busy, done);
endinterface

// File: rtl/bcd_digit_streamer_dd_adjust.sv
// Double-dabble correction: every nibble >= 5 gets +3 before the shift.
module dd_adjust
    import palindrome_pkg::*;
#(
    parameter int NDIG = 10
) (
    input  logic [NDIG-1:0][DIGIT_W-1:0] bcd_in,
    output logic [NDIG-1:0][DIGIT_W-1:0] bcd_out
);
    for (genvar g = 0; g < NDIG; g++) begin : g_nib
        assign bcd_out[g] = (bcd_in[g] >= DIGIT_W'(5)) ? bcd_in[g] + DIGIT_W'(3) : bcd_in[g];
    end
endmodule

// File: rtl/bcd_digit_streamer.sv
// Binary -> BCD via sequential double-dabble, then streams significant digits MSB-first.
module bcd_digit_streamer
    import palindrome_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NDIG  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    bcd_digit_streamer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t                      state, state_nxt;
    logic [WIDTH-1:0]            bin_sh;
    logic [NDIG-1:0][DIGIT_W-1:0] bcd, adj;
    logic [CW-1:0]               bit_cnt;
    logic [CNT_W-1:0]            idx, cnt_q, sig_cnt;
    logic                        done_q;
    logic                        streaming, hs;
    logic [NDIG*DIGIT_W+WIDTH-1:0] shifted;

    dd_adjust #(.NDIG(NDIG)) u_adj (.bcd_in(bcd), .bcd_out(adj));

    assign shifted   = {adj, bin_sh} << 1;
    assign streaming = (state == STREAM);
    assign hs        = streaming & bus.digit_ready;

    // Ascending scan: the highest non-zero nibble wins; all-zero reports one digit.
    always_comb begin
        sig_cnt = CNT_W'(1);
        for (int i = 0; i < NDIG; i++)
            if (bcd[i] != '0) sig_cnt = CNT_W'(i + 1);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CONVERT;
            CONVERT: if (bit_cnt == CW'(1)) state_nxt = SCAN;
            SCAN:    state_nxt = STREAM;
            STREAM:  if (hs && idx == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            bin_sh  <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
            idx     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    bin_sh  <= bus.bin_in;
                    bcd     <= '0;
                    bit_cnt <= CW'(WIDTH);
                end
                CONVERT: begin
                    {bcd, bin_sh} <= shifted;
                    bit_cnt       <= bit_cnt - CW'(1);
                end
                SCAN: begin
                    cnt_q <= sig_cnt;
                    idx   <= sig_cnt - CNT_W'(1);
                end
                STREAM: if (hs) begin
                    if (idx == '0) begin
                        done_q <= 1'b1;
                        cnt_q  <= '0;
                    end else begin
                        idx <= idx - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.digit_valid = streaming;
    assign bus.digit_out   = streaming ? bcd[idx] : '0;
    assign bus.digit_count = cnt_q;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
endmodule

// File: tb/tb_bcd_digit_streamer.sv
// Randomized and directed checks of the digit streamer against a decimal-digit model.
module tb_bcd_digit_streamer;
    localparam int WIDTH = 32;
    localparam int NDIG  = 10;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   exp_q[$];

    bcd_digit_streamer_if #(.WIDTH(WIDTH)) bus ();

    bcd_digit_streamer #(.WIDTH(WIDTH), .NDIG(NDIG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Decimal digits of v, most significant first.
    task automatic model(input longint unsigned v);
        exp_q.delete();
        do begin
            exp_q.push_front(int'(v % 10));
            v = v / 10;
        end while (v != 0);
    endtask

    task automatic run(input logic [31:0] v, input int pct, input int stall_idx, input bit poke);
        int lat, cyc, idx, stall, guard;
        model(longint'(v));
        bus.bin_in      = v;
        bus.start       = 1'b1;
        bus.digit_ready = 1'b0;
        step();
        bus.start = 1'b0;
        chk("busy_on", bus.busy, 1);
        chk("done_clr", bus.done, 0);
        lat = 1;
        while (!bus.digit_valid && lat < 200) begin
            if (poke && lat == 5) begin
                bus.bin_in = ~v;
                bus.start  = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            step();
            lat++;
        end
        bus.start = 1'b0;
        chk("latency", lat, WIDTH + 2);
        cyc = lat; idx = 0; stall = 0; guard = 0;
        while (idx < exp_q.size() && guard < 2000) begin
            if (idx == stall_idx && stall < 3) begin
                bus.digit_ready = 1'b0;
                stall++;
            end else begin
                bus.digit_ready = ($urandom_range(99) < pct);
            end
            chk("valid", bus.digit_valid, 1);
            chk("digit", bus.digit_out, exp_q[idx]);
            chk("count", bus.digit_count, exp_q.size());
            chk("busy", bus.busy, 1);
            if (bus.digit_ready) idx++;
            step();
            cyc++;
            guard++;
        end
        bus.digit_ready = 1'b0;
        if (pct == 100 && stall_idx < 0) chk("done_cyc", cyc, WIDTH + 2 + exp_q.size());
        chk("done", bus.done, 1);
        chk("busy_off", bus.busy, 0);
        chk("valid_off", bus.digit_valid, 0);
        chk("count_off", bus.digit_count, 0);
    endtask

    initial begin
        int lat;
        reset           = 1'b0;
        bus.start       = 1'b0;
        bus.bin_in      = '0;
        bus.digit_ready = 1'b0;
        step();
        step();
        chk("rst_valid", bus.digit_valid, 0);
        chk("rst_out", bus.digit_out, 0);
        chk("rst_count", bus.digit_count, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        reset = 1'b1;
        step();

        run(32'd12321, 100, -1, 1'b0);
        step();
        run(32'd0, 100, -1, 1'b0);
        step();
        run(32'hFFFF_FFFF, 100, -1, 1'b0);
        step();
        run(32'd907, 100, 1, 1'b0);
        step();
        run(32'd4711, 100, -1, 1'b1);
        // back-to-back: next start lands in the done cycle
        run(32'd8080, 100, -1, 1'b0);
        run(32'd65, 70, -1, 1'b0);
        step();

        // Abort mid-stream after two of five digits.
        model(64'd12345);
        bus.bin_in = 32'd12345;
        bus.start  = 1'b1;
        step();
        bus.start = 1'b0;
        lat = 1;
        while (!bus.digit_valid && lat < 200) begin
            step();
            lat++;
        end
        chk("abort_lat", lat, WIDTH + 2);
        bus.digit_ready = 1'b1;
        step();
        step();
        chk("abort_pre", bus.digit_out, exp_q[2]);
        reset = 1'b0;
        #1;
        chk("abort_valid", bus.digit_valid, 0);
        chk("abort_out", bus.digit_out, 0);
        chk("abort_count", bus.digit_count, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        bus.digit_ready = 1'b0;
        step();
        chk("abort_nodone", bus.done, 0);
        reset = 1'b1;
        step();
        chk("abort_idle", bus.done, 0);
        run(32'd121, 100, -1, 1'b0);

        for (int k = 0; k < 20; k++) begin
            logic [31:0] v;
            int pct;
            v = $urandom >> $urandom_range(31, 0);
            case ($urandom_range(2))
                0:       pct = 100;
                1:       pct = 50;
                default: pct = 25;
            endcase
            run(v, pct, -1, 1'b0);
            repeat ($urandom_range(2)) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
